sprite_anim_ctrl: RTL and testbench

//  Sequences one animated sprite (e.g. drum-hit burst) held as N_FRAMES stacked frames in a sprite ROM.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_frame_timer.sv | 49 ++++
 rtl/sprite_anim_ctrl.sv | 156 +++++++++++++++
 tb/tb_sprite_anim_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the animated sprite controller.
// Build option: SPRITE_MIRROR_EN adds a horizontal-mirror input.
package sprite_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } anim_state_t;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_ACTIVE = 640;

  function automatic int unsigned frame_base(
    input int unsigned f,
    input int unsigned w,
    input int unsigned h
  );
    return f * w * h;
  endfunction

endpackage

// File: rtl/sprite_frame_timer.sv
// Vertical frame tick detector and per-sprite-frame tick counter.
// Build option: none (SPRITE_MIRROR_EN only affects the top).
module sprite_frame_timer #(
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned TICKS_PF = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] draw_y,
  input  logic       clr,
  input  logic       run,
  output logic       frame_tick,
  output logic       adv
);
  localparam int unsigned CNT_W =
    (TICKS_PF > 1) ? $clog2(TICKS_PF) : 1;

  logic             at_v;
  logic             at_v_q;
  logic             last;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_v       = (draw_y == 10'(V_ACTIVE));
  assign frame_tick = at_v & ~at_v_q;
  assign last       = (cnt_q == CNT_W'(TICKS_PF - 1));
  assign adv        = run & frame_tick & ~clr & last;

  // A start pulse clears the count and swallows a coincident tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && frame_tick) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      at_v_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      at_v_q <= at_v;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Animated sprite sequencer: frame FSM, ROM address and pixel flag.
// Build option: SPRITE_MIRROR_EN adds input mirror (horizontal flip).
module sprite_anim_ctrl #(
  parameter int unsigned SPR_W    = 32,
  parameter int unsigned SPR_H    = 32,
  parameter int unsigned N_FRAMES = 4,
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned TICKS_PF = 6,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic                        vga_clk,
  input  logic                        reset_n,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic                        blank,
  input  logic [9:0]                  pos_x,
  input  logic [9:0]                  pos_y,
  input  logic                        start,
  input  logic                        loop,
`ifdef SPRITE_MIRROR_EN
  input  logic                        mirror,
`endif
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [IDX_W-1:0]            rom_q,
  output logic [IDX_W-1:0]            pix_index,
  output logic                        pix_valid,
  output logic [$clog2(N_FRAMES)-1:0] frame_idx,
  output logic                        busy,
  output logic                        done
);
  import sprite_pkg::*;

  localparam int unsigned FW = $clog2(N_FRAMES);

  anim_state_t       state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              loop_q, loop_d;
  logic              done_q, done_d;
  logic [9:0]        px_q, py_q;
  logic              frame_tick;
  logic              adv;
  logic [10:0]       dx, dy;
  logic              in_x, in_y, in_box;
  logic [ADDR_W-1:0] col, row, base;
  logic [IDX_W-1:0]  pix_index_q;
  logic              pix_valid_q;

  sprite_frame_timer #(
    .V_ACTIVE (V_ACTIVE),
    .TICKS_PF (TICKS_PF)
  ) u_timer (
    .clk        (vga_clk),
    .rst_n      (reset_n),
    .draw_y     (DrawY),
    .clr        (start),
    .run        (state_q == PLAY),
    .frame_tick (frame_tick),
    .adv        (adv)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = PLAY;
      frame_d = '0;
      loop_d  = loop;
    end else if (adv) begin
      if (frame_q != FW'(N_FRAMES - 1)) begin
        frame_d = frame_q + 1'b1;
      end else if (loop_q) begin
        frame_d = '0;
      end else begin
        state_d = IDLE;
        frame_d = '0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

  // Position only moves in vertical blank so a frame never tears.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q <= '0;
      py_q <= '0;
    end else if (frame_tick) begin
      px_q <= pos_x;
      py_q <= pos_y;
    end
  end

`ifdef SPRITE_MIRROR_EN
  logic mir_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      mir_q <= 1'b0;
    end else if (frame_tick) begin
      mir_q <= mirror;
    end
  end
`endif

  assign dx     = {1'b0, DrawX} - {1'b0, px_q};
  assign dy     = {1'b0, DrawY} - {1'b0, py_q};
  assign in_x   = (DrawX >= px_q) && (dx < 11'(SPR_W));
  assign in_y   = (DrawY >= py_q) && (dy < 11'(SPR_H));
  assign in_box = in_x & in_y;

`ifdef SPRITE_MIRROR_EN
  assign col = mir_q ? ADDR_W'(SPR_W - 1) - ADDR_W'(dx)
                     : ADDR_W'(dx);
`else
  assign col = ADDR_W'(dx);
`endif
  assign row  = ADDR_W'(dy);
  assign base = ADDR_W'(frame_base(32'(frame_q), SPR_W, SPR_H));

  assign rom_addr = in_box ? base + row * ADDR_W'(SPR_W) + col
                           : '0;

  // ROM answers on the falling edge; register it with its box flag.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_index_q <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_index_q <= rom_q;
      pix_valid_q <= in_box & blank & (|rom_q);
    end
  end

  assign pix_index = pix_index_q;
  assign pix_valid = pix_valid_q;
  assign frame_idx = frame_q;
  assign busy      = (state_q == PLAY);
  assign done      = done_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed vector bench for sprite_anim_ctrl.
// Build option: SPRITE_MIRROR_EN enables the mirror checks.
module tb_sprite_anim_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank, start, loop;
  logic [12:0] rom_addr;
  logic [5:0]  rom_q = '0;
  logic [5:0]  pix_index;
  logic        pix_valid;
  logic [1:0]  frame_idx;
  logic        busy, done;
  bit          rom_zero;
`ifdef SPRITE_MIRROR_EN
  logic        mirror;
`endif

  int nchk  = 0;
  int nerr  = 0;
  int done_cnt = 0;

  sprite_anim_ctrl dut (
    .vga_clk   (clk),
    .reset_n   (reset_n),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .blank     (blank),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .start     (start),
    .loop      (loop),
`ifdef SPRITE_MIRROR_EN
    .mirror    (mirror),
`endif
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .pix_index (pix_index),
    .pix_valid (pix_valid),
    .frame_idx (frame_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // ROM image: index = low address bits xor 0x2A.
  always @(negedge clk)
    rom_q <= rom_zero ? 6'd0 : (rom_addr[5:0] ^ 6'h2A);

  always @(negedge clk)
    if (done) done_cnt <= done_cnt + 1;

  typedef struct {
    int px; int py; int dx; int dy;
    bit blank; bit rz; bit tick;
    int addr; int valid; int idx;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic vtick(input bit st);
    @(posedge clk); #1 DrawY = 10'd479;
    @(posedge clk); #1 DrawY = 10'd480;
    start = st;
    if (st) loop = 1'b1;
    @(posedge clk); #1 DrawY = 10'd0;
    start = 1'b0;
  endtask

  initial begin
    vt[0]  = '{100, 50, 103, 52, 1, 0, 1,   67, 1, 41};
    vt[1]  = '{  0,  0, 103, 52, 1, 0, 0,   67, 1, 41};
    vt[2]  = '{100, 50, 132, 52, 1, 0, 1,    0, 0, 42};
    vt[3]  = '{100, 50, 100, 50, 1, 0, 1,    0, 1, 42};
    vt[4]  = '{100, 50, 131, 81, 1, 0, 1, 1023, 1, 21};
    vt[5]  = '{100, 50,  99, 50, 1, 0, 1,    0, 0, 42};
    vt[6]  = '{100, 50, 100, 82, 1, 0, 1,    0, 0, 42};
    vt[7]  = '{100, 50, 103, 52, 0, 0, 1,   67, 0, 41};
    vt[8]  = '{100, 50, 103, 52, 1, 1, 1,   67, 0,  0};
    vt[9]  = '{620,  0, 639,  0, 1, 0, 1,   19, 1, 57};
    vt[10] = '{620,  0,   0,  0, 1, 0, 1,    0, 0, 42};
    vt[11] = '{620,  0, 639, 31, 1, 0, 1, 1011, 1, 25};
    vt[12] = '{  0,470,   5,479, 1, 0, 1,  293, 1, 15};

    reset_n = 1'b0;
    DrawX = '0; DrawY = '0; pos_x = '0; pos_y = '0;
    blank = 1'b0; start = 1'b0; loop = 1'b0;
    rom_zero = 1'b0;
`ifdef SPRITE_MIRROR_EN
    mirror = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_frame", frame_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_index", pix_index, 0);
    chk("rst_addr", rom_addr, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      pos_x = 10'(vt[i].px);
      pos_y = 10'(vt[i].py);
      if (vt[i].tick) vtick(1'b0);
      @(posedge clk); #1;
      DrawX = 10'(vt[i].dx);
      DrawY = 10'(vt[i].dy);
      blank = vt[i].blank;
      rom_zero = vt[i].rz;
      #1 chk($sformatf("v%0d_addr", i), rom_addr, vt[i].addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), pix_valid, vt[i].valid);
      chk($sformatf("v%0d_index", i), pix_index, vt[i].idx);
    end
    rom_zero = 1'b0;
    DrawX = '0;
    DrawY = '0;

    // one-shot run
    @(posedge clk); #1 start = 1'b1; loop = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    chk("os_busy0", busy, 1);
    chk("os_frame0", frame_idx, 0);
    for (int k = 1; k <= 24; k++) begin
      vtick(1'b0);
      chk($sformatf("os_frame_k%0d", k), frame_idx, (k / 6) % 4);
      chk($sformatf("os_busy_k%0d", k), busy, int'(k < 24));
      chk($sformatf("os_done_k%0d", k), done, int'(k == 24));
    end
    @(posedge clk); #1;
    chk("os_done_clr", done, 0);
    chk("os_done_cnt", done_cnt, 1);

    // looping run with restarts
    @(posedge clk); #1 start = 1'b1; loop = 1'b1;
    @(posedge clk); #1 start = 1'b0; loop = 1'b0;
    for (int k = 1; k <= 38; k++) begin
      vtick(1'b0);
      if (k % 6 == 0 || k >= 37)
        chk($sformatf("lp_frame_k%0d", k), frame_idx, (k / 6) % 4);
    end
    chk("lp_busy", busy, 1);
    @(posedge clk); #1 start = 1'b1; loop = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("rs_frame", frame_idx, 0);
    chk("rs_busy", busy, 1);
    repeat (5) vtick(1'b0);
    chk("rs_frame5", frame_idx, 0);
    vtick(1'b1);
    chk("co_frame", frame_idx, 0);
    repeat (5) vtick(1'b0);
    chk("co_frame5", frame_idx, 0);
    vtick(1'b0);
    chk("co_frame6", frame_idx, 1);
    chk("lp_done_cnt", done_cnt, 1);

    // async reset in the middle of playback
    @(posedge clk); #1;
    DrawX = 10'd5; DrawY = 10'd479; blank = 1'b1;
    @(posedge clk); #1;
    chk("mr_valid_pre", pix_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_frame", frame_idx, 0);
    chk("mr_valid", pix_valid, 0);
    chk("mr_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mr_busy_post", busy, 0);
    chk("mr_done_cnt", done_cnt, 1);
    DrawX = '0; DrawY = '0; blank = 1'b0;

`ifdef SPRITE_MIRROR_EN
    pos_x = '0; pos_y = '0; mirror = 1'b1;
    @(posedge clk); #1 start = 1'b1; loop = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) vtick(1'b0);
    chk("mi_frame", frame_idx, 1);
    @(posedge clk); #1 DrawX = '0; DrawY = '0;
    #1 chk("mi_addr", rom_addr, 1055);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
